// File: rtl/radar_pulse_sequencer_pkg.sv
// Shared state encoding and default widths for the radar pulse sequencer slice.
package radar_seq_pkg;

    localparam int unsigned PHASE_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF  = 11;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned NP_W_DEF    = 8;
    localparam int unsigned ROM_LAT_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_GAP
    } seq_state_e;

endpackage

// File: rtl/radar_pulse_sequencer_if.sv
// Configuration / control / front-end bus between the config registers and the sequencer.
interface radar_pulse_sequencer_if
    import radar_seq_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned NP_W    = NP_W_DEF
);

    logic               start;
    logic               abort;
    logic [PHASE_W-1:0] cfg_fstart;
    logic [PHASE_W-1:0] cfg_kstep;
    logic [CNT_W-1:0]   cfg_pw;
    logic [CNT_W-1:0]   cfg_pri;
    logic [CNT_W-1:0]   cfg_rx_dly;
    logic [CNT_W-1:0]   cfg_rx_len;
    logic [NP_W-1:0]    cfg_npulse;

    logic [ADDR_W-1:0]  rom_addr;
    logic               tx_en;
    logic               rx_gate;
    logic               pulse_sync;
    logic               busy;
    logic               done;
    logic               cfg_err;

    modport master (
        output start, abort, cfg_fstart, cfg_kstep, cfg_pw, cfg_pri,
               cfg_rx_dly, cfg_rx_len, cfg_npulse,
        input  rom_addr, tx_en, rx_gate, pulse_sync, busy, done, cfg_err
    );

    modport slave (
        input  start, abort, cfg_fstart, cfg_kstep, cfg_pw, cfg_pri,
               cfg_rx_dly, cfg_rx_len, cfg_npulse,
        output rom_addr, tx_en, rx_gate, pulse_sync, busy, done, cfg_err
    );

endinterface

// File: rtl/radar_pulse_sequencer_dds_chirp_acc.sv
// Chirped DDS accumulator: phase advances by finc, finc advances by kstep, both mod 2^PHASE_W.
module dds_chirp_acc
    import radar_seq_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [PHASE_W-1:0] fstart,
    input  logic [PHASE_W-1:0] kstep,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] finc_q, finc_d;

    always_comb begin
        phase_d = phase_q;
        finc_d  = finc_q;
        if (load) begin
            phase_d = '0;
            finc_d  = fstart;
        end else if (step) begin
            phase_d = phase_q + finc_q;
            finc_d  = finc_q + kstep;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            finc_q  <= '0;
        end else begin
            phase_q <= phase_d;
            finc_q  <= finc_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/radar_pulse_sequencer.sv
// Pulse-train sequencer: FSM, PRI/pulse counters, receive gate and tx_en alignment for
// one coherent burst; the chirp phase comes from dds_chirp_acc.
module radar_pulse_sequencer
    import radar_seq_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned NP_W    = NP_W_DEF,
    parameter int unsigned ROM_LAT = ROM_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    radar_pulse_sequencer_if.slave bus
);

    localparam int unsigned TXD_W = ROM_LAT + 1;

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   p_q, p_d;
    logic [NP_W-1:0]    n_q, n_d;
    logic [PHASE_W-1:0] fstart_q, fstart_d, kstep_q, kstep_d;
    logic [CNT_W-1:0]   pw_q, pw_d, pri_q, pri_d, dly_q, dly_d, len_q, len_d;
    logic [NP_W-1:0]    np_q, np_d;
    logic               busy_q, busy_d, sync_q, sync_d, done_q, done_d;
    logic               err_q, err_d, rx_q, rx_d;
    logic [TXD_W-1:0]   txd_q, txd_d;
    logic               cfg_ok, acc_load, acc_step;
    logic [CNT_W:0]     req_end, gate_end;
    logic [PHASE_W-1:0] phase;

    always_comb begin
        req_end = {1'b0, bus.cfg_rx_dly} + {1'b0, bus.cfg_rx_len};
        cfg_ok  = (bus.cfg_pw != '0) && (bus.cfg_pri > bus.cfg_pw) &&
                  (bus.cfg_npulse != '0) && (req_end <= {1'b0, bus.cfg_pri});
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        n_d      = n_q;
        fstart_d = fstart_q;
        kstep_d  = kstep_q;
        pw_d     = pw_q;
        pri_d    = pri_q;
        dly_d    = dly_q;
        len_d    = len_q;
        np_d     = np_q;
        sync_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            p_d     = '0;
            n_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (cfg_ok) begin
                            fstart_d = bus.cfg_fstart;
                            kstep_d  = bus.cfg_kstep;
                            pw_d     = bus.cfg_pw;
                            pri_d    = bus.cfg_pri;
                            dly_d    = bus.cfg_rx_dly;
                            len_d    = bus.cfg_rx_len;
                            np_d     = bus.cfg_npulse;
                            state_d  = ST_TX;
                            p_d      = '0;
                            n_d      = '0;
                            sync_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_TX: begin
                    p_d = p_q + CNT_W'(1);
                    if (p_q == pw_q - CNT_W'(1)) state_d = ST_GAP;
                end
                ST_GAP: begin
                    if (p_q == pri_q - CNT_W'(1)) begin
                        p_d = '0;
                        if (n_q == np_q - NP_W'(1)) begin
                            state_d = ST_IDLE;
                            n_d     = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_TX;
                            n_d     = n_q + NP_W'(1);
                            sync_d  = 1'b1;
                        end
                    end else begin
                        p_d = p_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are registered from next-state values so they line up with p_q.
        busy_d   = (state_d != ST_IDLE);
        gate_end = {1'b0, dly_d} + {1'b0, len_d};
        rx_d     = busy_d && (p_d >= dly_d) && ({1'b0, p_d} < gate_end);
        txd_d    = bus.abort ? '0 : TXD_W'({txd_q, state_d == ST_TX});

        // Accumulator holds phase 0 whenever not mid-pulse, so rom_addr needs no output mask.
        acc_step = (state_q == ST_TX) && (state_d == ST_TX);
        acc_load = !acc_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            p_q      <= '0;
            n_q      <= '0;
            fstart_q <= '0;
            kstep_q  <= '0;
            pw_q     <= '0;
            pri_q    <= '0;
            dly_q    <= '0;
            len_q    <= '0;
            np_q     <= '0;
            busy_q   <= 1'b0;
            sync_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rx_q     <= 1'b0;
            txd_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            n_q      <= n_d;
            fstart_q <= fstart_d;
            kstep_q  <= kstep_d;
            pw_q     <= pw_d;
            pri_q    <= pri_d;
            dly_q    <= dly_d;
            len_q    <= len_d;
            np_q     <= np_d;
            busy_q   <= busy_d;
            sync_q   <= sync_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rx_q     <= rx_d;
            txd_q    <= txd_d;
        end
    end

    dds_chirp_acc #(
        .PHASE_W(PHASE_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (acc_load),
        .step  (acc_step),
        .fstart(fstart_d),
        .kstep (kstep_q),
        .phase (phase)
    );

    if (PHASE_W > ADDR_W) begin : g_phase_lsb
        logic unused_phase_lsb;
        assign unused_phase_lsb = ^phase[PHASE_W-ADDR_W-1:0];
    end

    assign bus.rom_addr   = phase[PHASE_W-1 -: ADDR_W];
    assign bus.tx_en      = txd_q[TXD_W-1];
    assign bus.rx_gate    = rx_q;
    assign bus.pulse_sync = sync_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_radar_pulse_sequencer.sv
// Self-checking bench: closed-form per-cycle reference model of a burst versus the sequencer.
module tb_radar_pulse_sequencer;

    localparam int unsigned ROM_LAT = 1;
    typedef longint unsigned u64_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    radar_pulse_sequencer_if #(
        .PHASE_W(32), .ADDR_W(11), .CNT_W(16), .NP_W(8)
    ) bus ();

    radar_pulse_sequencer #(
        .PHASE_W(32), .ADDR_W(11), .CNT_W(16), .NP_W(8), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_fstart, m_kstep;
    int unsigned m_pw, m_pri, m_dly, m_len, m_np;

    function automatic logic [16:0] observed();
        return {bus.rom_addr, bus.tx_en, bus.rx_gate, bus.pulse_sync,
                bus.busy, bus.done, bus.cfg_err};
    endfunction

    function automatic bit cfg_legal(int unsigned pw, int unsigned pri, int unsigned dly,
                                     int unsigned len, int unsigned np);
        return (pw >= 1) && (pri > pw) && (np >= 1) && (dly + len <= pri);
    endfunction

    // Expected outputs t cycles after the start-sampling edge (t=0 is S+1).
    function automatic logic [16:0] exp_vec(int unsigned t);
        int unsigned total, p;
        u64_t        tri_n;
        logic [31:0] ph;
        logic [10:0] addr;
        logic        txe, rxg, sy, bz, dn;
        total = m_np * m_pri;
        bz    = (t < total);
        p     = t % m_pri;
        addr  = '0;
        if (bz && p < m_pw) begin
            tri_n = (u64_t'(p) * u64_t'(p - 1)) / 2;
            ph    = 32'(u64_t'(p) * u64_t'(m_fstart) + tri_n * u64_t'(m_kstep));
            addr  = ph[31:21];
        end
        txe = (t >= ROM_LAT) && ((t - ROM_LAT) < total) && (((t - ROM_LAT) % m_pri) < m_pw);
        rxg = bz && (p >= m_dly) && (p < m_dly + m_len);
        sy  = bz && (p == 0);
        dn  = (t == total);
        return {addr, txe, rxg, sy, bz, dn, 1'b0};
    endfunction

    task automatic program_cfg(input logic [31:0] fs, input logic [31:0] ks,
                               input int unsigned pw, input int unsigned pri,
                               input int unsigned dly, input int unsigned len,
                               input int unsigned np, input bit to_model);
        bus.cfg_fstart = fs;
        bus.cfg_kstep  = ks;
        bus.cfg_pw     = 16'(pw);
        bus.cfg_pri    = 16'(pri);
        bus.cfg_rx_dly = 16'(dly);
        bus.cfg_rx_len = 16'(len);
        bus.cfg_npulse = 8'(np);
        if (to_model) begin
            m_fstart = fs; m_kstep = ks; m_pw = pw; m_pri = pri;
            m_dly = dly; m_len = len; m_np = np;
        end
    endtask

    task automatic scramble_cfg();
        bus.cfg_fstart = $urandom;
        bus.cfg_kstep  = $urandom;
        bus.cfg_pw     = 16'($urandom);
        bus.cfg_pri    = 16'($urandom);
        bus.cfg_rx_dly = 16'($urandom);
        bus.cfg_rx_len = 16'($urandom);
        bus.cfg_npulse = 8'($urandom);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        program_cfg(32'h1234_5678, 32'h1, 4, 10, 0, 3, 2, 1'b0);
        repeat (3) @(negedge clk);
        obs = observed();
        tests_run++;
        if (obs !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_hold got=%h exp=%h", obs, 17'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs = observed();
        tests_run++;
        if (obs !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_release got=%h exp=%h", obs, 17'h0);
        end
    endtask

    task automatic test_basic_burst();
        logic [16:0] obs, exp;
        program_cfg(32'h0020_0000, 32'h0, 4, 10, 0, 0, 3, 1'b1);
        pulse_start();
        for (int unsigned t = 0; t <= m_np * m_pri + 1; t++) begin
            obs = observed(); exp = exp_vec(t);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL basic_burst t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_chirp();
        logic [16:0] obs, exp;
        program_cfg(32'h0, 32'h0020_0000, 5, 8, 0, 8, 2, 1'b1);
        pulse_start();
        for (int unsigned t = 0; t <= m_np * m_pri + 1; t++) begin
            obs = observed(); exp = exp_vec(t);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL chirp t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rx_gate();
        logic [16:0] obs, exp;
        program_cfg($urandom, $urandom, 4, 10, 6, 3, 2, 1'b1);
        pulse_start();
        for (int unsigned t = 0; t <= m_np * m_pri + 1; t++) begin
            obs = observed(); exp = exp_vec(t);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL rx_gate t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(negedge clk);
        end
        program_cfg($urandom, $urandom, 4, 10, 8, 3, 2, 1'b0);
        pulse_start();
        obs = observed();
        tests_run++;
        if (obs !== 17'h1) begin
            tests_failed++;
            $display("FAIL rx_gate_cfg_err got=%h exp=%h", obs, 17'h1);
        end
        @(negedge clk);
        obs = observed();
        tests_run++;
        if (obs !== 17'h0) begin
            tests_failed++;
            $display("FAIL rx_gate_err_idle got=%h exp=%h", obs, 17'h0);
        end
    endtask

    task automatic test_abort();
        logic [16:0] obs, exp;
        program_cfg(32'h0020_0000, 32'h0, 4, 10, 2, 5, 3, 1'b1);
        pulse_start();
        for (int unsigned t = 0; t <= 12; t++) begin
            obs = observed(); exp = exp_vec(t);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL abort_pre t=%0d got=%h exp=%h", t, obs, exp);
            end
            if (t < 12) @(negedge clk);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            obs = observed();
            tests_run++;
            if (obs !== 17'h0) begin
                tests_failed++;
                $display("FAIL abort_clear c=%0d got=%h exp=%h", i, obs, 17'h0);
            end
            @(negedge clk);
        end
        program_cfg($urandom, $urandom, 3, 7, 1, 4, 2, 1'b1);
        pulse_start();
        for (int unsigned t = 0; t <= m_np * m_pri + 1; t++) begin
            obs = observed(); exp = exp_vec(t);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL abort_restart t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [16:0] obs, exp;
        program_cfg(32'hFFFF_FFFF, 32'h1, 3, 4, 3, 1, 1, 1'b1);
        pulse_start();
        for (int unsigned t = 0; t <= m_np * m_pri + 1; t++) begin
            obs = observed(); exp = exp_vec(t);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL wrap t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] obs, exp;
        int unsigned total;
        program_cfg($urandom, $urandom, 2, 5, 1, 2, 2, 1'b1);
        pulse_start();
        total = m_np * m_pri;
        for (int unsigned t = 0; t <= total; t++) begin
            obs = observed(); exp = exp_vec(t);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL b2b_first t=%0d got=%h exp=%h", t, obs, exp);
            end
            bus.start = 1'b0;
            if (t == 3) begin
                program_cfg($urandom, $urandom, 0, 3, 0, 9, 0, 1'b0);
                bus.start = 1'b1;
            end
            if (t == total) begin
                program_cfg($urandom, $urandom, 3, 6, 0, 6, 2, 1'b1);
                bus.start = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        for (int unsigned t = 0; t <= m_np * m_pri + 1; t++) begin
            obs = observed(); exp = exp_vec(t);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL b2b_second t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(negedge clk);
        end
        program_cfg($urandom, $urandom, 2, 5, 0, 1, 1, 1'b0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs = observed();
            tests_run++;
            if (obs !== 17'h0) begin
                tests_failed++;
                $display("FAIL start_abort c=%0d got=%h exp=%h", i, obs, 17'h0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [16:0] obs, exp;
        int unsigned pw, pri, dly, len, np, total;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                pw  = $urandom_range(1, 6);
                pri = pw + $urandom_range(1, 6);
                dly = $urandom_range(0, pri);
                len = $urandom_range(0, pri - dly);
                np  = $urandom_range(1, 3);
            end else begin
                pw  = $urandom_range(0, 6);
                pri = $urandom_range(0, 10);
                dly = $urandom_range(0, 10);
                len = $urandom_range(0, 10);
                np  = $urandom_range(0, 3);
            end
            if (cfg_legal(pw, pri, dly, len, np)) begin
                program_cfg($urandom, $urandom, pw, pri, dly, len, np, 1'b1);
                pulse_start();
                total = m_np * m_pri;
                for (int unsigned t = 0; t <= total + 1; t++) begin
                    obs = observed(); exp = exp_vec(t);
                    tests_run++;
                    if (obs !== exp) begin
                        tests_failed++;
                        $display("FAIL random it=%0d t=%0d got=%h exp=%h", it, t, obs, exp);
                    end
                    scramble_cfg();
                    bus.start = (t < total) && ($urandom_range(0, 7) == 0);
                    @(negedge clk);
                end
                bus.start = 1'b0;
            end else begin
                program_cfg($urandom, $urandom, pw, pri, dly, len, np, 1'b0);
                pulse_start();
                obs = observed();
                tests_run++;
                if (obs !== 17'h1) begin
                    tests_failed++;
                    $display("FAIL random_err it=%0d got=%h exp=%h", it, obs, 17'h1);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_chirp();
        test_rx_gate();
        test_abort();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
